cim_gemm_array: RTL and testbench
=================================

# cim_gemm_array

Parametrised, bit-serial compute-in-memory GeMM macro: successor to the fixed 8×8, 4-bit-input CIM block. It stores weights in a byte-addressed array, accepts one input vector per valid/ready handshake, and computes OUT_PAR dot products over IN_PREC cycles by MSB-first shift-add. It accumulates the results into per-column registers and exposes a selectable ADC-quantised output. It sits on the core's CIM bus in place of the previous macro.

## Interface
- DATA_WIDTH, 8, weight width (unsigned)
- ADDR_WIDTH, 10, weight array address bits; RAM_DEPTH = 2**ADDR_WIDTH
- IN_PREC, 4, input element bits (unsigned)
- IN_PAR, 8, input elements per vector
- OUT_PAR, 8, output columns (power of two); ROWS = RAM_DEPTH/OUT_PAR
- ACC_WIDTH, 32, accumulator width
- ADC_PRECISION, 6, quantised output bits
- ADC_LSB, 8, accumulator bit that maps to the quantiser LSB

- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- cs  in  1  chip select
- we  in  1  memory write enable
- address  in  32  byte address; low ADDR_WIDTH bits used
- wdata  in  32  write data, bytes [31:24]..[7:0] to address+0..+3
- rdata  out  32  registered read, {mem[a],mem[a+1],mem[a+2],mem[a+3]}
- cim_valid  in  1  start request
- cim_ready  out  1  start accepted when high with cim_valid
- cim_in  in  IN_PAR*IN_PREC  input vector; element i = bits [(IN_PAR-i)*IN_PREC-1 -: IN_PREC]
- cim_base  in  $clog2(ROWS)  first weight row
- acc_clear  in  1  sampled at accept: replace accumulators instead of adding
- done  out  1  one-cycle pulse, accumulators updated
- out_sel  in  $clog2(OUT_PAR)  column to present
- out_data  out  32  quantised accumulator of column out_sel

## Operation
- Weight of column c, row r is stored at byte address c*ROWS + r.
- FSM states:
  - IDLE → COMPUTE on accept.
  - COMPUTE holds bit counter b = IN_PREC-1 down to 0, then → WB.
  - WB → IDLE.
- cim_ready = (state==IDLE) && !(cs && we).
- At accept, latch cim_in, cim_base and acc_clear; clear all partial registers.
- Each COMPUTE cycle, per column c: part_c <= (part_c<<1) + Σ_i bit_b(in_i)·w[c][(base+i) mod ROWS]. Row index wraps within the column.
- Partial width is DATA_WIDTH + $clog2(IN_PAR) + IN_PREC; no overflow is possible.
- In WB: acc_c <= acc_clear ? part_c : acc_c + part_c. Accumulation is unsigned and wraps mod 2**ACC_WIDTH.
- Memory writes (cs && we) are performed only in IDLE. Writes in other states are dropped.
- Memory reads (cs && !we) are allowed in any state.
- Addresses a+1..a+3 wrap mod RAM_DEPTH.
- out_data is combinational from acc[out_sel] through the quantiser. Default quantiser: the window w = acc[ADC_LSB+ADC_PRECISION-1 : ADC_LSB], sign-extended from its MSB to 32 bits.
- rst:
  - Forces IDLE.
  - Zeroes acc, part, rdata and done. out_data therefore resets to 0.
  - Does not clear the weight array.
  - Reset mid-COMPUTE aborts the operation and does not pulse done.

## Timing
- Accept at edge T. COMPUTE occupies cycles T+1..T+IN_PREC, WB is cycle T+IN_PREC+1, and done is high in cycle T+IN_PREC+2.
- acc and out_data show the new value in the done cycle. cim_ready is high in that cycle, so back-to-back starts are allowed.
- rdata latency is 1 cycle. rdata holds its value when no read occurs.
- If cs&&we and cim_valid coincide in IDLE: the write happens and the start is deferred.

## Configuration
- CIM_ADC_SAT_EN defined: the quantiser saturates. If acc ≥ 2**(ADC_LSB+ADC_PRECISION-1), out_data = 2**(ADC_PRECISION-1)-1; otherwise out_data = w, zero-extended.
- CIM_ADC_SAT_EN undefined: legacy wrap/sign-extend window as in Operation.

## Structure
- Package cim_pkg holds:
  - state enum (IDLE, COMPUTE, WB)
  - ROWS, partial-width and select-width localparams
  - quantiser function (both macro variants)
- Sub-module cim_column_mac: one column's bit-serial dot product and shift-add partial register, instantiated OUT_PAR times. Weights are supplied as a flat vector by the top.

## Test plan
- Write 0xA1B2C3D4 at address 5, then read address 5 → rdata = 0xA1B2C3D4 one cycle later. Byte at address 7 reads 0xC3.
- Column 0 rows 0..7 = 255, cim_in = all 0xF, acc_clear=1 → done at T+6, acc0 = 30600 (0x7788).
  - Default build: out_data = 0xFFFFFFF7.
  - CIM_ADC_SAT_EN: out_data = 31.
- Column 3 rows 0..7 = 64, inputs all 4: first op with acc_clear=1 → out_data(sel 3) = 8. Second op with acc_clear=0 → 16. Other columns stay 0.
- cim_base = 124, ones at column 1 rows 124..127 and 0..3, inputs all 1 → acc1 = 8, confirming row wrap.
- cim_valid together with cs&&we in IDLE → write lands, no accept that cycle, accept on the next cycle. A write issued during COMPUTE leaves memory unchanged.
- Assert rst at T+2 of an operation → no done, acc = 0, out_data = 0, cim_ready = 1 the cycle after rst deasserts, weights retained.

Source files
------------

// File: rtl/cim_pkg.sv
// cim_pkg: shared types, default geometry and the ADC quantiser for the CIM GeMM macro.
// CIM_ADC_SAT_EN selects a saturating quantiser instead of the wrap/sign-extend window.
package cim_pkg;

    typedef enum logic [1:0] {IDLE, COMPUTE, WB} state_t;

    localparam int DATA_WIDTH_D = 8;
    localparam int ADDR_WIDTH_D = 10;
    localparam int IN_PREC_D    = 4;
    localparam int IN_PAR_D     = 8;
    localparam int OUT_PAR_D    = 8;
    localparam int ROWS         = (2 ** ADDR_WIDTH_D) / OUT_PAR_D;
    localparam int ROW_W        = $clog2(ROWS);
    localparam int SEL_W        = $clog2(OUT_PAR_D);
    localparam int PART_W       = DATA_WIDTH_D + $clog2(IN_PAR_D) + IN_PREC_D;

    function automatic logic [31:0] quantise(input logic [63:0] acc, input int lsb, input int prec);
        logic [63:0] mask;
        logic [63:0] w;
        mask = (64'd1 << prec) - 64'd1;
        w    = (acc >> lsb) & mask;
`ifdef CIM_ADC_SAT_EN
        quantise = ((acc >> (lsb + prec - 1)) != 64'd0) ? 32'((64'd1 << (prec - 1)) - 64'd1) : w[31:0];
`else
        quantise = w[prec-1] ? 32'(w | ~mask) : w[31:0];
`endif
    endfunction

endpackage

// File: rtl/cim_gemm_array_if.sv
// cim_gemm_array_if: CIM bus (memory port, start handshake, result select) between core and macro.
interface cim_gemm_array_if
    import cim_pkg::*;
#(
    parameter int IN_PAR_P  = IN_PAR_D,
    parameter int IN_PREC_P = IN_PREC_D,
    parameter int ROW_W_P   = ROW_W,
    parameter int SEL_W_P   = SEL_W
);
    logic                            cs;
    logic                            we;
    logic [31:0]                     address;
    logic [31:0]                     wdata;
    logic [31:0]                     rdata;
    logic                            cim_valid;
    logic                            cim_ready;
    logic [IN_PAR_P*IN_PREC_P-1:0]   cim_in;
    logic [ROW_W_P-1:0]              cim_base;
    logic                            acc_clear;
    logic                            done;
    logic [SEL_W_P-1:0]              out_sel;
    logic [31:0]                     out_data;

    modport master (
        output cs, we, address, wdata, cim_valid, cim_in, cim_base, acc_clear, out_sel,
        input  rdata, cim_ready, done, out_data
    );

    modport slave (
        input  cs, we, address, wdata, cim_valid, cim_in, cim_base, acc_clear, out_sel,
        output rdata, cim_ready, done, out_data
    );
endinterface

// File: rtl/cim_column_mac.sv
// cim_column_mac: one column's bit-serial dot product, MSB-first shift-add into a partial register.
module cim_column_mac #(
    parameter int DATA_WIDTH = 8,
    parameter int IN_PAR     = 8,
    parameter int PART_W     = 15
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear,
    input  logic                         en,
    input  logic [IN_PAR-1:0]            bits,
    input  logic [IN_PAR*DATA_WIDTH-1:0] weights,
    output logic [PART_W-1:0]            part
);
    logic [PART_W-1:0] sum;

    always_comb begin
        sum = '0;
        for (int i = 0; i < IN_PAR; i++)
            sum = sum + (bits[i] ? PART_W'(weights[i*DATA_WIDTH +: DATA_WIDTH]) : '0);
    end

    always_ff @(posedge clk) begin
        if (rst || clear)
            part <= '0;
        else if (en)
            part <= (part << 1) + sum;
    end
endmodule

// File: rtl/cim_gemm_array.sv
// cim_gemm_array: bit-serial compute-in-memory GeMM macro with byte-addressed weight store.
// Define CIM_ADC_SAT_EN for a saturating output quantiser (default: wrap/sign-extend window).
module cim_gemm_array
    import cim_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 10,
    parameter int IN_PREC       = 4,
    parameter int IN_PAR        = 8,
    parameter int OUT_PAR       = 8,
    parameter int ACC_WIDTH     = 32,
    parameter int ADC_PRECISION = 6,
    parameter int ADC_LSB       = 8
) (
    input logic             clk,
    input logic             rst,
    cim_gemm_array_if.slave bus
);
    localparam int RAM_DEPTH = 2 ** ADDR_WIDTH;
    localparam int N_ROWS    = RAM_DEPTH / OUT_PAR;
    localparam int N_ROW_W   = $clog2(N_ROWS);
    localparam int N_SEL_W   = $clog2(OUT_PAR);
    localparam int N_PART_W  = DATA_WIDTH + $clog2(IN_PAR) + IN_PREC;
    localparam int CNT_W     = IN_PREC > 1 ? $clog2(IN_PREC) : 1;

    state_t                            state;
    logic [CNT_W-1:0]                  cnt;
    logic [IN_PAR*IN_PREC-1:0]         in_q;
    logic [N_ROW_W-1:0]                base_q;
    logic                              clr_q;
    logic [DATA_WIDTH-1:0]             mem [RAM_DEPTH];
    logic [ACC_WIDTH-1:0]              acc [OUT_PAR];
    logic [OUT_PAR-1:0][N_PART_W-1:0]  part;
    logic [IN_PAR-1:0]                 bits;
    logic [ADDR_WIDTH-1:0]             a;
    logic                              wr, rd, start;
    logic                              unused_addr;

    assign a             = bus.address[ADDR_WIDTH-1:0];
    assign unused_addr   = ^bus.address[31:ADDR_WIDTH];
    assign wr            = bus.cs && bus.we;
    assign rd            = bus.cs && !bus.we;
    assign bus.cim_ready = (state == IDLE) && !wr;
    assign start         = bus.cim_valid && bus.cim_ready;
    assign bus.out_data  = quantise(64'(acc[bus.out_sel]), ADC_LSB, ADC_PRECISION);

    // Weight array is deliberately outside reset so stored weights survive rst.
    always_ff @(posedge clk) begin
        if (wr && state == IDLE)
            for (int k = 0; k < 4; k++)
                mem[a + ADDR_WIDTH'(k)] <= DATA_WIDTH'(bus.wdata[31-8*k -: 8]);
    end

    always_ff @(posedge clk) begin
        if (rst)
            bus.rdata <= '0;
        else if (rd)
            for (int k = 0; k < 4; k++)
                bus.rdata[31-8*k -: 8] <= 8'(mem[a + ADDR_WIDTH'(k)]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            in_q     <= '0;
            base_q   <= '0;
            clr_q    <= 1'b0;
            bus.done <= 1'b0;
            for (int c = 0; c < OUT_PAR; c++)
                acc[c] <= '0;
        end else begin
            bus.done <= 1'b0;
            if (state == IDLE && start) begin
                state  <= COMPUTE;
                cnt    <= CNT_W'(IN_PREC - 1);
                in_q   <= bus.cim_in;
                base_q <= bus.cim_base;
                clr_q  <= bus.acc_clear;
            end else if (state == COMPUTE) begin
                cnt <= cnt - CNT_W'(1);
                if (cnt == '0)
                    state <= WB;
            end else if (state == WB) begin
                state    <= IDLE;
                bus.done <= 1'b1;
                for (int c = 0; c < OUT_PAR; c++)
                    acc[c] <= clr_q ? ACC_WIDTH'(part[c]) : acc[c] + ACC_WIDTH'(part[c]);
            end
        end
    end

    // Element 0 sits in the most significant slice of the input vector.
    always_comb begin
        bits = '0;
        for (int i = 0; i < IN_PAR; i++)
            bits[i] = in_q[(IN_PAR-1-i)*IN_PREC + int'(cnt)];
    end

    genvar c;
    for (c = 0; c < OUT_PAR; c++) begin : g_col
        logic [IN_PAR*DATA_WIDTH-1:0] w_flat;

        // Row index wraps inside the column, so the column select never changes.
        always_comb begin
            w_flat = '0;
            for (int i = 0; i < IN_PAR; i++)
                w_flat[i*DATA_WIDTH +: DATA_WIDTH] = mem[{N_SEL_W'(c), N_ROW_W'(base_q + N_ROW_W'(i))}];
        end

        cim_column_mac #(
            .DATA_WIDTH(DATA_WIDTH),
            .IN_PAR    (IN_PAR),
            .PART_W    (N_PART_W)
        ) u_mac (
            .clk    (clk),
            .rst    (rst),
            .clear  (start),
            .en     (state == COMPUTE),
            .bits   (bits),
            .weights(w_flat),
            .part   (part[c])
        );
    end
endmodule

// File: tb/tb_cim_gemm_array.sv
// tb_cim_gemm_array: table-driven ops plus hand sequences, with a scoreboard of expected column outputs.
module tb_cim_gemm_array;
    import cim_pkg::*;

    typedef logic [7:0][31:0] exp_t;
    typedef struct {
        int          fcol;
        int          frow;
        int          nw;
        logic [7:0]  wv;
        logic [3:0]  nib;
        int          base;
        bit          clr;
        int          ccol;
        logic [31:0] e_def;
        logic [31:0] e_sat;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [7:0]  mem_m [1024];
    logic [31:0] acc_m [8];
    exp_t        sb [$];
    vec_t        tbl [5];

    always #10 clk = ~clk;

    cim_gemm_array_if #(.IN_PAR_P(8), .IN_PREC_P(4), .ROW_W_P(7), .SEL_W_P(3)) bus ();

    cim_gemm_array dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    function automatic logic [31:0] quant_m(input logic [31:0] v);
        logic [31:0] w;
        w = (v >> 8) & 32'd63;
`ifdef CIM_ADC_SAT_EN
        return (v >= 32'd8192) ? 32'd31 : w;
`else
        return w[5] ? (32'hFFFF_FFC0 | w) : w;
`endif
    endfunction

    function automatic logic [31:0] mword(input int addr);
        logic [31:0] r;
        for (int k = 0; k < 4; k++)
            r[31-8*k -: 8] = mem_m[(addr + k) % 1024];
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic wr(input int addr, input logic [31:0] d);
        @(negedge clk);
        bus.cs = 1'b1; bus.we = 1'b1; bus.address = addr; bus.wdata = d;
        for (int k = 0; k < 4; k++)
            mem_m[(addr + k) % 1024] = d[31-8*k -: 8];
        @(negedge clk);
        bus.cs = 1'b0; bus.we = 1'b0;
    endtask

    task automatic rd_check(input string name, input int addr, input logic [31:0] exp);
        @(negedge clk);
        bus.cs = 1'b1; bus.we = 1'b0; bus.address = addr;
        @(negedge clk);
        bus.cs = 1'b0;
        check(name, bus.rdata, exp);
    endtask

    // Direct (non bit-serial) dot product of the whole input value against the weight model.
    task automatic model_accept(input logic [31:0] in, input int base, input bit clr);
        exp_t        e;
        logic [31:0] p;
        for (int c = 0; c < 8; c++) begin
            p = 0;
            for (int i = 0; i < 8; i++)
                p += 32'(mem_m[c*128 + (base + i) % 128]) * 32'(in[(7-i)*4 +: 4]);
            acc_m[c] = clr ? p : acc_m[c] + p;
            e[c] = quant_m(acc_m[c]);
        end
        sb.push_back(e);
    endtask

    task automatic compare_sb();
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL sb_pop: got empty scoreboard, expected one entry");
            return;
        end
        checks--;
        e = sb.pop_front();
        for (int c = 0; c < 8; c++) begin
            bus.out_sel = 3'(c);
            #1;
            check($sformatf("out_col%0d", c), bus.out_data, e[c]);
        end
        @(negedge clk);
        check("done_pulse_one_cycle", {31'd0, bus.done}, 32'd0);
    endtask

    task automatic finish_op(input logic [31:0] in, input int base, input bit clr, input bit wr_mid);
        int k;
        @(posedge clk);
        model_accept(in, base, clr);
        k = 0;
        do begin
            @(negedge clk);
            k++;
            if (k == 1) begin
                bus.cim_valid = 1'b0;
                if (wr_mid) begin
                    bus.cs = 1'b1; bus.we = 1'b1; bus.address = 601; bus.wdata = 32'hDEAD_BEEF;
                end
            end
            if (k == 2) begin
                bus.cs = 1'b0; bus.we = 1'b0;
            end
        end while (!bus.done && k < 20);
        check("done_latency", 32'(k), 32'd6);
        check("ready_in_done", {31'd0, bus.cim_ready}, 32'd1);
        compare_sb();
    endtask

    task automatic run_op(input logic [31:0] in, input int base, input bit clr);
        int n;
        @(negedge clk);
        bus.cim_valid = 1'b1; bus.cim_in = in; bus.cim_base = 7'(base); bus.acc_clear = clr;
        #1;
        n = 0;
        while (!bus.cim_ready && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("accept_ready", {31'd0, bus.cim_ready}, 32'd1);
        finish_op(in, base, clr, 1'b0);
    endtask

    initial begin
        bit seen_done;
        bus.cs = 0; bus.we = 0; bus.address = 0; bus.wdata = 0; bus.cim_valid = 0;
        bus.cim_in = 0; bus.cim_base = 0; bus.acc_clear = 0; bus.out_sel = 0;
        for (int c = 0; c < 8; c++) acc_m[c] = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_ready", {31'd0, bus.cim_ready}, 32'd1);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_rdata", bus.rdata, 32'd0);
        check("rst_out_data", bus.out_data, 32'd0);

        for (int addr = 0; addr < 1024; addr += 4) wr(addr, 32'd0);

        wr(5, 32'hA1B2_C3D4);
        rd_check("rd_addr5", 5, 32'hA1B2_C3D4);
        @(negedge clk);
        check("rdata_hold", bus.rdata, 32'hA1B2_C3D4);
        rd_check("rd_addr7", 7, 32'hC3D4_0000);
        check("rd_addr7_byte", {24'd0, bus.rdata[31:24]}, 32'h0000_00C3);
        wr(1023, 32'h1122_3344);
        rd_check("rd_wrap_1023", 1023, mword(1023));
        rd_check("rd_wrap_0", 0, 32'h2233_4400);
        wr(1020, 32'd0);
        wr(0, 32'd0);

        tbl[0] = '{0, 0,   2, 8'hFF, 4'hF, 0,   1'b1, 0, 32'hFFFF_FFF7, 32'd31};
        tbl[1] = '{0, 0,   2, 8'h00, 4'h0, 0,   1'b1, 0, 32'd0,         32'd0};
        tbl[2] = '{3, 0,   2, 8'd64, 4'h4, 0,   1'b1, 3, 32'd8,         32'd8};
        tbl[3] = '{0, 0,   0, 8'h00, 4'h4, 0,   1'b0, 3, 32'd16,        32'd16};
        tbl[4] = '{1, 124, 2, 8'd64, 4'h1, 124, 1'b1, 1, 32'd2,         32'd2};
        for (int t = 0; t < 5; t++) begin
            for (int j = 0; j < tbl[t].nw; j++)
                wr(tbl[t].fcol*128 + (tbl[t].frow + 4*j) % 128, {4{tbl[t].wv}});
            run_op({8{tbl[t].nib}}, tbl[t].base, tbl[t].clr);
            bus.out_sel = 3'(tbl[t].ccol);
            #1;
`ifdef CIM_ADC_SAT_EN
            check($sformatf("tbl%0d_col%0d", t, tbl[t].ccol), bus.out_data, tbl[t].e_sat);
`else
            check($sformatf("tbl%0d_col%0d", t, tbl[t].ccol), bus.out_data, tbl[t].e_def);
`endif
        end

        // Write collides with start in IDLE: write wins, start waits one cycle; a write mid-op is dropped.
        @(negedge clk);
        bus.cs = 1'b1; bus.we = 1'b1; bus.address = 600; bus.wdata = 32'h0BAD_F00D;
        bus.cim_valid = 1'b1; bus.cim_in = 32'hFFFF_FFFF; bus.cim_base = 0; bus.acc_clear = 1'b1;
        for (int k = 0; k < 4; k++) mem_m[600 + k] = bus.wdata[31-8*k -: 8];
        #1;
        check("collide_ready_low", {31'd0, bus.cim_ready}, 32'd0);
        @(negedge clk);
        bus.cs = 1'b0; bus.we = 1'b0;
        #1;
        check("deferred_ready", {31'd0, bus.cim_ready}, 32'd1);
        finish_op(32'hFFFF_FFFF, 0, 1'b1, 1'b1);
        rd_check("collide_write_landed", 600, 32'h0BAD_F00D);
        rd_check("compute_write_dropped", 601, mword(601));

        // Reset two cycles into an operation.
        @(negedge clk);
        bus.cim_valid = 1'b1; bus.cim_in = 32'h7777_7777; bus.cim_base = 0; bus.acc_clear = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.cim_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_ready", {31'd0, bus.cim_ready}, 32'd1);
        check("post_rst_rdata", bus.rdata, 32'd0);
        seen_done = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bus.done) seen_done = 1'b1;
        end
        check("abort_no_done", {31'd0, seen_done}, 32'd0);
        for (int c = 0; c < 8; c++) begin
            bus.out_sel = 3'(c);
            #1;
            check($sformatf("abort_out_col%0d", c), bus.out_data, 32'd0);
        end
        rd_check("weights_kept_col3", 3*128, 32'h4040_4040);
        rd_check("weights_kept_col1", 128 + 124, 32'h4040_4040);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
